// File: rtl/oam_dma_ctrl.sv
// Sprite DMA bus master: on a CPU write to the DMA register, halts the 6502 and copies one page to PPU OAM.
// Latency: rdy drops the cycle after the trigger; 512 bus cycles plus HALT/ALIGN; the CPU is stalled via rdy.
module oam_dma_ctrl #(
    parameter int              ADDR_WIDTH    = 16,
    parameter int              REG_WIDTH     = 8,
    parameter logic [15:0]     DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0]     OAM_DATA_ADDR = 16'h2004,
    parameter int              XFER_LEN      = 256
) (
    input  logic                  phi0,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_data_out,
    input  logic                  cpu_r_w_n,
    input  logic [REG_WIDTH-1:0]  bus_data_in,
    output logic                  rdy,
    output logic                  bus_grant,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic [REG_WIDTH-1:0]  dma_data_out,
    output logic                  dma_r_w_n,
    output logic                  dma_active
);

    localparam int IDX_W = $clog2(XFER_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t               state_q, state_d;
    logic                 p_q;
    logic [REG_WIDTH-1:0] page_q, page_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [REG_WIDTH-1:0] buf_q, buf_d;

    always_ff @(posedge phi0) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= 1'b0;
            page_q  <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= ~p_q;
            page_q  <= page_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (!cpu_r_w_n && cpu_addr == ADDR_WIDTH'(DMA_REG_ADDR)) begin
                    page_d  = cpu_data_out;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // The 6502 ignores rdy during writes, so wait for its first read cycle.
                // Exiting on p=1 puts every READ on a get slot.
                if (cpu_r_w_n) begin
                    state_d = p_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                buf_d   = bus_data_in;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == IDX_W'(XFER_LEN - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rdy          = (state_q == S_IDLE);
    assign dma_active   = (state_q != S_IDLE);
    assign bus_grant    = (state_q == S_READ) || (state_q == S_WRITE);
    assign dma_r_w_n    = (state_q != S_WRITE);
    assign dma_data_out = (state_q == S_WRITE) ? buf_q : '0;

    always_comb begin
        dma_addr = '0;
        if (state_q == S_READ) begin
            dma_addr = ADDR_WIDTH'({page_q, idx_q});
        end else if (state_q == S_WRITE) begin
            dma_addr = ADDR_WIDTH'(OAM_DATA_ADDR);
        end
    end

endmodule
